mult_dot_accumulator: RTL and testbench

Downstream consumer of the pipelined multiplier. It tracks operand-valid and last-of-vector flags through a delay line matched to the multiplier latency, and sums each product stream into a dot-product result. Completed sums are presented on a valid/ready output port. The multiplier has no stall input, so this block never back-pressures it; instead, a result that cannot be delivered is dropped and flagged.

---
 rtl/mult_dot_accumulator_if.sv | 37 +++
 rtl/mult_dot_accumulator.sv | 156 +++++++++++++++
 tb/tb_mult_dot_accumulator.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_dot_accumulator_if.sv
// Operand-flag / product / result bundle for mult_dot_accumulator.
// The sat signal exists only when ACC_SATURATE_EN is defined.
interface mult_dot_accumulator_if #(
    parameter int SIZE  = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 12
);
    localparam int RC_W = $clog2(LEN + 1);

    logic                op_valid;
    logic                op_last;
    logic [2*SIZE-1:0]   pdt;
    logic [ACC_W-1:0]    res_data;
    logic [RC_W-1:0]     res_count;
    logic                res_valid;
    logic                res_ready;
    logic                ovf;
`ifdef ACC_SATURATE_EN
    logic                sat;
`endif

    modport master (
        output op_valid, op_last, pdt, res_ready,
        input  res_data, res_count, res_valid, ovf
`ifdef ACC_SATURATE_EN
        , input sat
`endif
    );

    modport slave (
        input  op_valid, op_last, pdt, res_ready,
        output res_data, res_count, res_valid, ovf
`ifdef ACC_SATURATE_EN
        , output sat
`endif
    );
endinterface

// File: rtl/mult_dot_accumulator.sv
// Dot-product accumulator behind a pipelined multiplier, with a one-entry valid/ready result
// register that drops results it cannot hold. ACC_SATURATE_EN selects clamping over wrapping.
module mult_dot_accumulator #(
    parameter int SIZE  = 4,
    parameter int LEVEL = 2,
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_dot_accumulator_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int RC_W  = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } hold_state_e;

    logic [LEVEL:0]   vld_q, vld_d;
    logic [LEVEL:0]   lst_q, lst_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hold_state_e      state_q, state_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic [RC_W-1:0]  res_count_q, res_count_d;
    logic             ovf_q, ovf_d;

    logic             d_valid;
    logic             d_last;
    logic             vec_end;
    logic             complete;
    logic             handshake;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic [RC_W-1:0]  term_count;

`ifdef ACC_SATURATE_EN
    logic             sat_q, sat_d;
    logic [ACC_W:0]   sum_wide;
    logic             clamp;
`endif

    always_comb begin
        // Flag delay line; last is qualified by valid at the input so stale last bits never matter.
        vld_d[0] = bus.op_valid;
        lst_d[0] = bus.op_valid & bus.op_last;
        for (int unsigned i = 1; i <= LEVEL; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    assign d_valid = vld_q[LEVEL];
    assign d_last  = lst_q[LEVEL];

    always_comb begin
        base = (cnt_q == '0) ? '0 : acc_q;
`ifdef ACC_SATURATE_EN
        sum_wide = {1'b0, base} + (ACC_W+1)'(bus.pdt);
        clamp    = sum_wide[ACC_W];
        sum      = clamp ? '1 : sum_wide[ACC_W-1:0];
`else
        sum      = base + ACC_W'(bus.pdt);
`endif
        term_count = RC_W'(cnt_q) + RC_W'(1);
        vec_end    = d_last || (cnt_q == CNT_LAST);
        complete   = d_valid && vec_end;
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (d_valid) begin
            if (vec_end) begin
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef ACC_SATURATE_EN
    assign sat_d = sat_q | (d_valid & clamp);
`endif

    assign handshake = (state_q == FULL) && bus.res_ready;

    always_comb begin
        state_d     = state_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        ovf_d       = ovf_q;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d     = FULL;
                    res_data_d  = sum;
                    res_count_d = term_count;
                end
            end
            FULL: begin
                if (handshake) begin
                    if (complete) begin
                        res_data_d  = sum;
                        res_count_d = term_count;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (complete) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= EMPTY;
            res_data_q  <= '0;
            res_count_q <= '0;
            ovf_q       <= 1'b0;
`ifdef ACC_SATURATE_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            ovf_q       <= ovf_d;
`ifdef ACC_SATURATE_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign bus.res_valid = (state_q == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_count = res_count_q;
    assign bus.ovf       = ovf_q;
`ifdef ACC_SATURATE_EN
    assign bus.sat       = sat_q;
`endif
endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Bench for mult_dot_accumulator: two instances (defaults, and ACC_W=10/LEN=8) share one
// operand stream from a behavioural multiplier; every cycle is checked against an arithmetic model.
module tb_mult_dot_accumulator;
    localparam int SIZE  = 4;
    localparam int LEVEL = 2;
    localparam int LEN0  = 4;
    localparam int W0    = 12;
    localparam int LEN1  = 8;
    localparam int W1    = 10;
    localparam int LAT   = LEVEL + 2;
    localparam int MAXC  = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic op_valid = 1'b0;
    logic op_last = 1'b0;
    logic res_ready = 1'b0;
    logic [SIZE-1:0] a = '0;
    logic [SIZE-1:0] b = '0;
    logic [2*SIZE-1:0] p_pipe [LEVEL+1];

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Behavioural multiplier: unreset pipeline, product appears LEVEL+1 edges after the operands.
    always @(posedge clk) begin
        p_pipe[0] <= (2*SIZE)'(a) * (2*SIZE)'(b);
        for (int i = 1; i <= LEVEL; i++) p_pipe[i] <= p_pipe[i-1];
    end

    mult_dot_accumulator_if #(.SIZE(SIZE), .LEN(LEN0), .ACC_W(W0)) bus0 ();
    mult_dot_accumulator_if #(.SIZE(SIZE), .LEN(LEN1), .ACC_W(W1)) bus1 ();

    assign bus0.op_valid  = op_valid;
    assign bus0.op_last   = op_last;
    assign bus0.pdt       = p_pipe[LEVEL];
    assign bus0.res_ready = res_ready;
    assign bus1.op_valid  = op_valid;
    assign bus1.op_last   = op_last;
    assign bus1.pdt       = p_pipe[LEVEL];
    assign bus1.res_ready = res_ready;

    mult_dot_accumulator #(.SIZE(SIZE), .LEVEL(LEVEL), .LEN(LEN0), .ACC_W(W0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );
    mult_dot_accumulator #(.SIZE(SIZE), .LEVEL(LEVEL), .LEN(LEN1), .ACC_W(W1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    // Input history per cycle; cycle c inputs are sampled at edge c+1.
    bit hv [MAXC];
    bit hl [MAXC];
    int hp [MAXC];
    bit hy [MAXC];
    bit hr [MAXC];
    int cyc = 0;
    int last_rst = -1;

    int m_acc [2];
    int m_cnt [2];
    int m_data [2];
    int m_count [2];
    bit m_held [2];
    bit m_ovf [2];
`ifdef ACC_SATURATE_EN
    bit m_sat [2];
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model over edge number cyc.
    task automatic model_edge();
        int in_c = cyc - 1;
        int c = cyc - LAT;
        bit term;
        if (hr[in_c]) begin
            last_rst = in_c;
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_data[k] = 0; m_count[k] = 0;
                m_held[k] = 0; m_ovf[k] = 0;
`ifdef ACC_SATURATE_EN
                m_sat[k] = 0;
`endif
            end
            return;
        end
        // A product counts only if its operands were valid and no reset fell while it was in flight.
        term = (c >= 0) && hv[c] && (last_rst < c);
        for (int k = 0; k < 2; k++) begin
            int len = (k == 0) ? LEN0 : LEN1;
            int maxv = (k == 0) ? (1 << W0) - 1 : (1 << W1) - 1;
            bit done = 0;
            int sum = 0;
            int terms = 0;
            if (term) begin
                sum = (m_cnt[k] == 0) ? hp[c] : m_acc[k] + hp[c];
                if (sum > maxv) begin
`ifdef ACC_SATURATE_EN
                    sum = maxv;
                    m_sat[k] = 1;
`else
                    sum = sum % (maxv + 1);
`endif
                end
                terms = m_cnt[k] + 1;
                if (hl[c] || terms == len) begin
                    done = 1;
                    m_cnt[k] = 0;
                end else begin
                    m_acc[k] = sum;
                    m_cnt[k] = terms;
                end
            end
            if (!m_held[k]) begin
                if (done) begin m_held[k] = 1; m_data[k] = sum; m_count[k] = terms; end
            end else if (hy[in_c]) begin
                if (done) begin m_data[k] = sum; m_count[k] = terms; end
                else m_held[k] = 0;
            end else if (done) begin
                m_ovf[k] = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("u0.valid", 32'(bus0.res_valid), 32'(m_held[0]));
        chk("u0.data",  32'(bus0.res_data),  32'(m_data[0]));
        chk("u0.count", 32'(bus0.res_count), 32'(m_count[0]));
        chk("u0.ovf",   32'(bus0.ovf),       32'(m_ovf[0]));
        chk("u1.valid", 32'(bus1.res_valid), 32'(m_held[1]));
        chk("u1.data",  32'(bus1.res_data),  32'(m_data[1]));
        chk("u1.count", 32'(bus1.res_count), 32'(m_count[1]));
        chk("u1.ovf",   32'(bus1.ovf),       32'(m_ovf[1]));
`ifdef ACC_SATURATE_EN
        chk("u0.sat",   32'(bus0.sat),       32'(m_sat[0]));
        chk("u1.sat",   32'(bus1.sat),       32'(m_sat[1]));
`endif
    endtask

    task automatic step(input bit v, input bit l, input int ai, input int bi,
                        input bit rdy, input bit rst);
        op_valid = v; op_last = l; res_ready = rdy; rst_n = !rst;
        a = SIZE'(ai); b = SIZE'(bi);
        hv[cyc] = v; hl[cyc] = l; hp[cyc] = ai * bi; hy[cyc] = rdy; hr[cyc] = rst;
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'($urandom), int'($urandom_range(15)), int'($urandom_range(15)), rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, int'($urandom_range(15)), int'($urandom_range(15)), 1'b0, 1'b1);
    endtask

    // Bounded wait for a result on instance k, then check it against spec constants.
    task automatic wait_res(input int k, input string tag, input int ed, input int ec, input bit rdy);
        bit got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            got = (k == 0) ? (bus0.res_valid === 1'b1) : (bus1.res_valid === 1'b1);
            if (!got) idle(rdy);
        end
        chk({tag, ".seen"}, 32'(got), 32'd1);
        chk({tag, ".data"},  (k == 0) ? 32'(bus0.res_data)  : 32'(bus1.res_data),  32'(ed));
        chk({tag, ".count"}, (k == 0) ? 32'(bus0.res_count) : 32'(bus1.res_count), 32'(ec));
    endtask

    initial begin
        do_reset();
        do_reset();
        chk("rst.valid", 32'(bus0.res_valid), 32'd0);
        chk("rst.data",  32'(bus0.res_data),  32'd0);
        chk("rst.count", 32'(bus0.res_count), 32'd0);
        chk("rst.ovf",   32'(bus0.ovf),       32'd0);

        // Latency: 3x5 last at cycle 0, visible in cycle 4.
        step(1'b1, 1'b1, 3, 5, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("lat.early", 32'(bus0.res_valid), 32'd0);
        idle(1'b0);
        chk("lat.valid", 32'(bus0.res_valid), 32'd1);
        chk("lat.data",  32'(bus0.res_data),  32'd15);
        chk("lat.count", 32'(bus0.res_count), 32'd1);
        idle(1'b1);
        chk("lat.drain", 32'(bus0.res_valid), 32'd0);

        // Full vector ends at LEN terms, then the next vector starts from zero.
        step(1'b1, 1'b0, 1, 2, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3, 4, 1'b1, 1'b0);
        step(1'b1, 1'b0, 5, 6, 1'b1, 1'b0);
        step(1'b1, 1'b0, 7, 8, 1'b1, 1'b0);
        wait_res(0, "full", 100, 4, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b1, 2, 3, 1'b0, 1'b0);
        wait_res(0, "next", 6, 1, 1'b0);
        idle(1'b1);

        // Overflow drop while the consumer stalls.
        step(1'b1, 1'b1, 2, 2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3, 3, 1'b0, 1'b0);
        wait_res(0, "ovf", 4, 1, 1'b0);
        idle(1'b0);
        chk("ovf.flag", 32'(bus0.ovf),      32'd1);
        chk("ovf.held", 32'(bus0.res_data), 32'd4);
        idle(1'b1);
        chk("ovf.drain", 32'(bus0.res_valid), 32'd0);
        idle(1'b0);
        chk("ovf.sticky", 32'(bus0.ovf), 32'd1);

        // Accept and complete in the same cycle.
        do_reset();
        chk("rst2.ovf", 32'(bus0.ovf), 32'd0);
        step(1'b1, 1'b1, 1, 1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2, 2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3, 3, 1'b1, 1'b0);
        wait_res(0, "b2b1", 1, 1, 1'b1);
        idle(1'b1);
        chk("b2b2.data", 32'(bus0.res_data), 32'd4);
        idle(1'b1);
        chk("b2b3.data", 32'(bus0.res_data), 32'd9);
        chk("b2b3.valid", 32'(bus0.res_valid), 32'd1);
        idle(1'b1);
        chk("b2b.end", 32'(bus0.res_valid), 32'd0);
        chk("b2b.ovf", 32'(bus0.ovf), 32'd0);

        // Reset while two 15x15 terms are in flight.
        step(1'b1, 1'b0, 15, 15, 1'b1, 1'b0);
        step(1'b1, 1'b0, 15, 15, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 1'b1, 1, 1, 1'b1, 1'b0);
        wait_res(0, "rstmid", 1, 1, 1'b1);
        idle(1'b1);

        // Eight 15x15 terms on the 10-bit, LEN=8 instance.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 15, 15, 1'b1, 1'b0);
`ifdef ACC_SATURATE_EN
        wait_res(1, "wide", 1023, 8, 1'b1);
        chk("wide.sat", 32'(bus1.sat), 32'd1);
`else
        wait_res(1, "wide", 776, 8, 1'b1);
`endif
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0), ($urandom_range(2) == 0),
                 int'($urandom_range(15)), int'($urandom_range(15)),
                 ($urandom_range(1) == 1), ($urandom_range(49) == 0));
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
